tick_ctrl: RTL
==============

Name: tick_ctrl

Overview:
Upstream timing stage for the LED chaser. It generates the one-cycle `tick` enable that advances the chaser shift register. Tick rate is selected from switches. Two push-buttons are debounced and give pause/resume and single-step control. Runs on the 50 MHz board clock; `tick` drops straight into the chaser's `if (tick)` advance condition.

Parameters:
- BASE_PERIOD, 25_000_000, tick period in clk cycles at speed=0 (0.5 s at 50 MHz)
- DEBOUNCE_CYCLES, 500_000, consecutive stable synced cycles required to accept a key level change (10 ms)
- SPEED_W, 3, width of speed select

Ports:
- clk  in  1  50 MHz board clock
- reset  in  1  synchronous reset, active-high
- speed  in  SPEED_W  rate select (sw); period = BASE_PERIOD >> speed
- key_pause_n  in  1  raw pause/resume button, active-low, asynchronous
- key_step_n  in  1  raw single-step button, active-low, asynchronous
- tick  out  1  one-cycle advance pulse
- running  out  1  1 = RUN state, 0 = PAUSE
- speed_q  out  SPEED_W  speed value currently in effect

Behaviour:
- One clock `clk`. Reset is synchronous, active-high: all state is updated only on posedge clk while reset=1.
- Reset values: tick=0, running=1 (state RUN), speed_q=0, cnt=0. Synchronizer flops reset to 1 (released key). Debounced levels reset to 1. Debounce counters reset to 0.
- Key path, identical per key:
  - 2-FF synchronizer.
  - Debounce counter: if the synced value differs from the debounced level, the counter increments; otherwise it clears. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - press pulse = debounced level goes 1→0 (registered edge detect).
  - Release produces no pulse. Bounces shorter than DEBOUNCE_CYCLES are fully rejected.
- Period arithmetic:
  - period_q = BASE_PERIOD >> speed_q, unsigned, width $clog2(BASE_PERIOD+1).
  - If period_q evaluates to 0, it is treated as 1 (tick every cycle).
- FSM states: RUN, PAUSE.
  - RUN:
    - cnt increments each cycle.
    - When cnt == period_q-1: cnt←0, speed_q←speed, tick=1 on the next cycle. Tick is a registered output, 1 cycle wide.
    - First tick after reset release occurs when period_q cycles have elapsed.
    - pause press → PAUSE; cnt←0 and no tick that cycle. A pending wrap in the same cycle is discarded.
    - step press ignored.
  - PAUSE:
    - cnt held at 0; speed_q←speed every cycle.
    - step press → tick=1 exactly on the next cycle, then stay in PAUSE.
    - pause press → RUN with cnt=0, so the first tick comes one full period after resume.
- Simultaneous pause and step press in the same cycle: pause wins and step is dropped, in both states.
- Speed changes in RUN take effect only at the next wrap; a running period is never truncated or extended.
- Reset asserted mid-period or mid-debounce: everything returns to reset values, and any in-flight tick is suppressed.
- running = (state == RUN), registered.

Optional Feature:
TICK_CTRL_DEBOUNCE_EN
- Defined: debounce counters active, as described above.
- Undefined: debounce counters removed; the debounced level equals the synced level, giving a press-to-FSM latency of 3 cycles (2-FF sync + edge register). Intended for fast simulation and lab demos with clean inputs.
- All other behaviour is identical.

Decomposition:
- Package tick_ctrl_pkg holds:
  - state enum {RUN, PAUSE}
  - default constants TICK_BASE_PERIOD_DFLT=25_000_000 and TICK_DEBOUNCE_DFLT=500_000
  - function period_of(speed) implementing the shift and the clamp to 1
- Sub-module key_debounce: sync + debounce + falling-edge pulse. Ports: clk, reset, key_n, level, press. Instantiated twice.

Test Plan:
(BASE_PERIOD=16, DEBOUNCE_CYCLES=4 unless stated)
1. Reset, speed=0, keys high, run 100 cycles → tick pulses 1 cycle wide, spaced exactly 16 cycles; running=1.
2. speed=2 → pulse spacing 4; change speed to 0 mid-period → the current period completes at spacing 4, then spacing becomes 16; speed_q updates at the wrap.
3. key_pause_n low for 3 cycles then high (glitch) → no state change. Low for 10 cycles → running=0 with exact latency (2 sync + 4 debounce + 1 edge); no further ticks.
4. In PAUSE, press step 3 times → exactly 3 single ticks. Press pause again → running=1 and first tick 16 cycles after resume.
5. Pause and step pressed with aligned edges while in RUN → PAUSE entered, zero ticks emitted.
6. Assert reset mid-period (cnt=9) for 1 cycle → tick=0, running=1, speed_q=0, next tick 16 cycles after release. With TICK_CTRL_DEBOUNCE_EN undefined, the press latency in test 3 becomes 3 cycles.

Source files
------------

// File: rtl/tick_ctrl_pkg.sv
// Shared state type, default timing constants and period helper
// for the LED chaser tick stage.
package tick_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  localparam int unsigned TICK_BASE_PERIOD_DFLT = 25_000_000;
  localparam int unsigned TICK_DEBOUNCE_DFLT    = 500_000;

  // A period that shifts down to zero still ticks every cycle.
  function automatic int unsigned period_of(
    input int unsigned base,
    input int unsigned spd
  );
    int unsigned p;
    p = base >> spd;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button path: 2-FF sync, optional debounce, falling-edge press.
// Debounce counter present only with TICK_CTRL_DEBOUNCE_EN defined.
module key_debounce
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = TICK_DEBOUNCE_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic w_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level_d <= 1'b1;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      r_level_d <= w_level;
    end
  end

`ifdef TICK_CTRL_DEBOUNCE_EN
  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  assign level = w_level;
  assign press = r_level_d & ~w_level;

endmodule

// File: rtl/tick_ctrl.sv
// LED chaser tick generator: rate select, pause/resume, single-step.
// Key debounce enabled by defining TICK_CTRL_DEBOUNCE_EN.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = TICK_BASE_PERIOD_DFLT,
  parameter int unsigned DEBOUNCE_CYCLES = TICK_DEBOUNCE_DFLT,
  parameter int unsigned SPEED_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SPEED_W-1:0] speed,
  input  logic               key_pause_n,
  input  logic               key_step_n,
  output logic               tick,
  output logic               running,
  output logic [SPEED_W-1:0] speed_q
);

  localparam int unsigned PW = $clog2(BASE_PERIOD + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_cnt;
  logic [PW-1:0]      w_cnt_nxt;
  logic [PW-1:0]      w_period;
  logic [SPEED_W-1:0] r_speed_q;
  logic [SPEED_W-1:0] w_speed_nxt;
  logic               r_tick;
  logic               w_tick_nxt;
  logic               w_wrap;
  logic               w_pause_press;
  logic               w_step_press;
  logic [1:0]         w_unused_lvl;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_pause (
    .clk   (clk),
    .reset (reset),
    .key_n (key_pause_n),
    .level (w_unused_lvl[0]),
    .press (w_pause_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_step (
    .clk   (clk),
    .reset (reset),
    .key_n (key_step_n),
    .level (w_unused_lvl[1]),
    .press (w_step_press)
  );

  assign w_period = PW'(period_of(BASE_PERIOD, 32'(r_speed_q)));
  assign w_wrap   = (r_cnt == w_period - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_speed_q <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_speed_q <= w_speed_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Pause outranks both a pending wrap and a same-cycle step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_speed_nxt = r_speed_q;
    w_tick_nxt  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_pause_press) begin
          w_state_nxt = PAUSE;
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_speed_nxt = speed;
          w_tick_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PAUSE: begin
        w_cnt_nxt   = '0;
        w_speed_nxt = speed;
        if (w_pause_press) begin
          w_state_nxt = RUN;
        end else if (w_step_press) begin
          w_tick_nxt = 1'b1;
        end
      end
    endcase
  end

  assign tick    = r_tick;
  assign running = (r_state == RUN);
  assign speed_q = r_speed_q;

endmodule
